// File: rtl/stim_pkg.sv
// Shared encodings and the golden reduction for the stimulus sweep checker.
package stim_pkg;

    // Sweep sequence selection
    localparam logic [1:0] MODE_BIN     = 2'b00;
    localparam logic [1:0] MODE_GRAY    = 2'b01;
    localparam logic [1:0] MODE_WALK    = 2'b10;
    localparam logic [1:0] MODE_BIN_ALT = 2'b11;

    // Golden reduction selection
    localparam logic [1:0] FUNC_OR  = 2'b00;
    localparam logic [1:0] FUNC_AND = 2'b01;
    localparam logic [1:0] FUNC_XOR = 2'b10;
    localparam logic [1:0] FUNC_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Reduction over the low 'width' bits of pat; upper bits are ignored so
    // AND is not polluted by the zero padding.
    function automatic logic golden(input logic [15:0] pat, input int width,
                                    input logic [1:0] func);
        logic r_or;
        logic r_and;
        logic r_xor;
        logic r;
        r_or  = 1'b0;
        r_and = 1'b1;
        r_xor = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < width) begin
                r_or  = r_or  | pat[i];
                r_and = r_and & pat[i];
                r_xor = r_xor ^ pat[i];
            end
        end
        case (func)
            FUNC_OR:  r = r_or;
            FUNC_AND: r = r_and;
            FUNC_XOR: r = r_xor;
            FUNC_NOR: r = ~r_or;
            default:  r = r_or;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stim_sweep_checker_if.sv
// Bundle of control, stimulus and result signals between a bench/lab top and the checker.
interface stim_sweep_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [1:0]       func;
    logic [WIDTH-1:0] pattern;
    logic             pattern_valid;
    logic             resp;
    logic             busy;
    logic             done;
    logic [ERR_W-1:0] err_cnt;
    logic             first_err_vld;
    logic [WIDTH-1:0] first_err_pat;

    modport master (
        output start, mode, func, resp,
        input  pattern, pattern_valid, busy, done, err_cnt, first_err_vld, first_err_pat
    );

    modport slave (
        input  start, mode, func, resp,
        output pattern, pattern_valid, busy, done, err_cnt, first_err_vld, first_err_pat
    );
endinterface

// File: rtl/stim_pattern_enc.sv
// Maps a sweep index and sequence mode to the stimulus pattern and a last-index flag.
module stim_pattern_enc
    import stim_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   idx,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] pattern,
    output logic             last
);

    // Pattern and terminal index for the selected sequence
    always_comb begin
        pattern = idx[WIDTH-1:0];
        last    = (idx == {1'b0, {WIDTH{1'b1}}});
        case (mode)
            MODE_BIN, MODE_BIN_ALT: begin
                pattern = idx[WIDTH-1:0];
            end
            MODE_GRAY: begin
                pattern = idx[WIDTH-1:0] ^ idx[WIDTH:1];
            end
            MODE_WALK: begin
                for (int b = 0; b < WIDTH; b++) begin
                    pattern[b] = (idx == (WIDTH+1)'(b));
                end
                last = (idx == (WIDTH+1)'(WIDTH - 1));
            end
            default: begin
                pattern = idx[WIDTH-1:0];
            end
        endcase
    end

endmodule

// File: rtl/stim_sweep_checker.sv
// Exhaustive stimulus sweep engine: drives patterns, samples a 1-bit response,
// checks it against a golden reduction and tracks mismatches.
module stim_sweep_checker
    import stim_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int HOLD  = 2,
    parameter int ERR_W = 8
) (
    input logic               clk,
    input logic               rst,
    stim_sweep_checker_if.slave bus
);

    localparam int              HC_W      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);

    state_t           state_q, state_d;
    logic [WIDTH:0]   idx_q, idx_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       func_q, func_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fvld_q, fvld_d;
    logic [WIDTH-1:0] fpat_q, fpat_d;

    logic [WIDTH-1:0] enc_pat;
    logic             enc_last;
    logic             hold_last;
    logic             sample;
    logic             mismatch;

    stim_pattern_enc #(.WIDTH(WIDTH)) u_enc (
        .idx     (idx_q),
        .mode    (mode_q),
        .pattern (enc_pat),
        .last    (enc_last)
    );

    // The response is only trusted on the final hold cycle, after HOLD-1 cycles of settling
    always_comb begin
        hold_last = (hold_q == HOLD_LAST);
        sample    = (state_q == ST_DRIVE) && hold_last;
        mismatch  = sample && (bus.resp != golden(16'(enc_pat), WIDTH, func_q));
    end

    // State and datapath registers; reset aborts a sweep with no done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            mode_q  <= '0;
            func_q  <= '0;
            err_q   <= '0;
            fvld_q  <= 1'b0;
            fpat_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            func_q  <= func_d;
            err_q   <= err_d;
            fvld_q  <= fvld_d;
            fpat_q  <= fpat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_DRIVE;
            ST_DRIVE: if (sample && enc_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Index/hold stepping, start-time latching and mismatch bookkeeping
    always_comb begin
        idx_d  = idx_q;
        hold_d = hold_q;
        mode_d = mode_q;
        func_d = func_q;
        err_d  = err_q;
        fvld_d = fvld_q;
        fpat_d = fpat_q;
        if (state_q == ST_IDLE && bus.start) begin
            mode_d = bus.mode;
            func_d = bus.func;
            idx_d  = '0;
            hold_d = '0;
            err_d  = '0;
            fvld_d = 1'b0;
            fpat_d = '0;
        end else if (state_q == ST_DRIVE) begin
            if (hold_last) begin
                hold_d = '0;
                if (!enc_last) idx_d = idx_q + 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
            if (mismatch) begin
                if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
                if (!fvld_q) begin
                    fvld_d = 1'b1;
                    fpat_d = enc_pat;
                end
            end
        end
    end

    // Outputs decoded from state; pattern stays on its last value through DONE
    always_comb begin
        bus.busy          = (state_q == ST_DRIVE);
        bus.pattern_valid = (state_q == ST_DRIVE);
        bus.done          = (state_q == ST_DONE);
        bus.pattern       = (state_q == ST_IDLE) ? '0 : enc_pat;
        bus.err_cnt       = err_q;
        bus.first_err_vld = fvld_q;
        bus.first_err_pat = fpat_q;
    end

endmodule
